sr_debouncer: RTL and testbench

SR_DEBOUNCER -- requirements
Module: sr_debouncer

---
 rtl/sr_debouncer_pkg.sv | 14 +
 rtl/sr_debouncer_if.sv | 23 ++
 rtl/sr_debounce_chan.sv | 115 +++++++++++
 rtl/sr_debouncer.sv | 54 +++++
 tb/tb_sr_debouncer.sv | 186 ++++++++++++++++++
 5 files changed

// File: rtl/sr_debouncer_pkg.sv
// Shared types and defaults for the SR debouncer: per-channel FSM state and default filter length.
package sr_debouncer_pkg;

  localparam int DEBOUNCE_CYCLES_DEF = 8;
  localparam int CNT_W_DEF           = 8;

  typedef enum logic [1:0] {
    ST_STABLE_LOW  = 2'd0,
    ST_COUNT_HIGH  = 2'd1,
    ST_STABLE_HIGH = 2'd2,
    ST_COUNT_LOW   = 2'd3
  } db_state_t;

endpackage

// File: rtl/sr_debouncer_if.sv
// Button-side and latch-side signals of the SR debouncer.
// The master drives the raw buttons; the slave (the debouncer) drives everything else.
interface sr_debouncer_if;
  logic set_raw;
  logic reset_raw;
  logic set_db;
  logic reset_db;
  logic set_pulse;
  logic reset_pulse;
  logic q;
  logic q_n;
  logic invalid;

  modport master (
    output set_raw, reset_raw,
    input  set_db, reset_db, set_pulse, reset_pulse, q, q_n, invalid
  );

  modport slave (
    input  set_raw, reset_raw,
    output set_db, reset_db, set_pulse, reset_pulse, q, q_n, invalid
  );
endinterface

// File: rtl/sr_debounce_chan.sv
// One debounce channel: optional 2-flop synchronizer (SR_DEBOUNCER_SYNC_EN), 4-state FSM with
// saturating run counter, registered debounced level and rising-edge strobe.
//
// state          | meaning
// ST_STABLE_LOW  | accepted level 0, waiting for a 1 sample
// ST_COUNT_HIGH  | accepted level 0, counting consecutive 1 samples
// ST_STABLE_HIGH | accepted level 1, waiting for a 0 sample
// ST_COUNT_LOW   | accepted level 1, counting consecutive 0 samples
module sr_debounce_chan
  import sr_debouncer_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int CNT_W           = CNT_W_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_raw,
  output logic o_db,
  output logic o_pulse
);

  localparam logic [CNT_W-1:0] TC  = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  logic w_sample;

`ifdef SR_DEBOUNCER_SYNC_EN
  logic [1:0] r_sync;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_sync <= 2'b00;
    else        r_sync <= {r_sync[0], i_raw};
  end

  assign w_sample = r_sync[1];
`else
  assign w_sample = i_raw;
`endif

  db_state_t        r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic             r_db, r_pulse, w_db_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_STABLE_LOW;
      r_cnt   <= '0;
      r_db    <= 1'b0;
      r_pulse <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_db    <= w_db_nxt;
      r_pulse <= w_db_nxt & ~r_db;
    end
  end

  // >= instead of == keeps the counter saturated even if it were ever disturbed
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    unique case (r_state)
      ST_STABLE_LOW: begin
        if (w_sample) begin
          w_state_nxt = ST_COUNT_HIGH;
          w_cnt_nxt   = ONE;
        end else begin
          w_cnt_nxt   = '0;
        end
      end
      ST_COUNT_HIGH: begin
        if (!w_sample) begin
          w_state_nxt = ST_STABLE_LOW;
          w_cnt_nxt   = '0;
        end else if (r_cnt >= TC) begin
          w_state_nxt = ST_STABLE_HIGH;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt   = r_cnt + ONE;
        end
      end
      ST_STABLE_HIGH: begin
        if (!w_sample) begin
          w_state_nxt = ST_COUNT_LOW;
          w_cnt_nxt   = ONE;
        end else begin
          w_cnt_nxt   = '0;
        end
      end
      ST_COUNT_LOW: begin
        if (w_sample) begin
          w_state_nxt = ST_STABLE_HIGH;
          w_cnt_nxt   = '0;
        end else if (r_cnt >= TC) begin
          w_state_nxt = ST_STABLE_LOW;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt   = r_cnt + ONE;
        end
      end
      default: begin
        w_state_nxt = ST_STABLE_LOW;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  always_comb begin
    w_db_nxt = (w_state_nxt == ST_STABLE_HIGH) || (w_state_nxt == ST_COUNT_LOW);
  end

  assign o_db    = r_db;
  assign o_pulse = r_pulse;

endmodule

// File: rtl/sr_debouncer.sv
// Debounced SR button pair: two debounce channels feeding a reset-dominant q/q_n latch.
// Optional input synchronizers are enabled with the SR_DEBOUNCER_SYNC_EN macro.
module sr_debouncer
  import sr_debouncer_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int CNT_W           = CNT_W_DEF
) (
  input logic           clk,
  input logic           rst_n,
  sr_debouncer_if.slave io_bus
);

  logic w_set_db, w_set_pulse, w_reset_db, w_reset_pulse;
  logic r_q;

  sr_debounce_chan #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .CNT_W           (CNT_W)
  ) u_set_chan (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_raw   (io_bus.set_raw),
    .o_db    (w_set_db),
    .o_pulse (w_set_pulse)
  );

  sr_debounce_chan #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .CNT_W           (CNT_W)
  ) u_reset_chan (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_raw   (io_bus.reset_raw),
    .o_db    (w_reset_db),
    .o_pulse (w_reset_pulse)
  );

  // reset strobe wins when both buttons are accepted on the same edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)             r_q <= 1'b0;
    else if (w_reset_pulse) r_q <= 1'b0;
    else if (w_set_pulse)   r_q <= 1'b1;
  end

  assign io_bus.set_db      = w_set_db;
  assign io_bus.reset_db    = w_reset_db;
  assign io_bus.set_pulse   = w_set_pulse;
  assign io_bus.reset_pulse = w_reset_pulse;
  assign io_bus.q           = r_q;
  assign io_bus.q_n         = ~r_q;
  assign io_bus.invalid     = w_set_db & w_reset_db;

endmodule

// File: tb/tb_sr_debouncer.sv
// Self-checking bench for sr_debouncer (DEBOUNCE_CYCLES=4, no synchronizer): directed scenarios
// with literal expectations, then randomized button activity against a sample-window model.
module tb_sr_debouncer;

  localparam int N = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  sr_debouncer_if bus ();

  sr_debouncer #(
    .DEBOUNCE_CYCLES (N),
    .CNT_W           (8)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .io_bus (bus)
  );

  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  // model: a level is accepted once the last N samples since the previous acceptance all disagree with it
  bit m_db_s, m_db_r, m_pulse_s, m_pulse_r, m_q;
  bit hist_s[$];
  bit hist_r[$];

  function automatic bit window_flips(bit h[$], bit db);
    if (h.size() < N) return 1'b0;
    foreach (h[i]) if (h[i] == db) return 1'b0;
    return 1'b1;
  endfunction

  function automatic void model_reset();
    m_db_s = 0; m_db_r = 0; m_pulse_s = 0; m_pulse_r = 0; m_q = 0;
    hist_s.delete();
    hist_r.delete();
  endfunction

  function automatic void model_edge(bit s, bit r);
    if (m_pulse_r)      m_q = 1'b0;
    else if (m_pulse_s) m_q = 1'b1;
    hist_s.push_back(s);
    if (hist_s.size() > N) void'(hist_s.pop_front());
    hist_r.push_back(r);
    if (hist_r.size() > N) void'(hist_r.pop_front());
    m_pulse_s = 0;
    m_pulse_r = 0;
    if (window_flips(hist_s, m_db_s)) begin
      m_db_s = ~m_db_s; m_pulse_s = m_db_s; hist_s.delete();
    end
    if (window_flips(hist_r, m_db_r)) begin
      m_db_r = ~m_db_r; m_pulse_r = m_db_r; hist_r.delete();
    end
  endfunction

  task automatic chk(string name, logic act, logic exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    else n_pass++;
  endtask

  task automatic cmp_all();
    chk("set_db",      bus.set_db,      m_db_s);
    chk("reset_db",    bus.reset_db,    m_db_r);
    chk("set_pulse",   bus.set_pulse,   m_pulse_s);
    chk("reset_pulse", bus.reset_pulse, m_pulse_r);
    chk("q",           bus.q,           m_q);
    chk("q_n",         bus.q_n,         ~m_q);
    chk("invalid",     bus.invalid,     m_db_s & m_db_r);
  endtask

  // drive, take one edge, update model with what that edge sampled, then compare
  task automatic step(bit s, bit r);
    bus.set_raw   = s;
    bus.reset_raw = r;
    @(posedge clk);
    if (rst_n) model_edge(s, r);
    else       model_reset();
    #1;
    cmp_all();
  endtask

  task automatic assert_reset();
    rst_n = 1'b0;
    model_reset();
    #1;
    cmp_all();
  endtask

  initial begin
    bus.set_raw   = 1'b1;
    bus.reset_raw = 1'b0;
    model_reset();
    #1;
    cmp_all();

    // reset held with set pressed: nothing may move
    step(1, 0);
    step(1, 0);
    chk("rst_q",      bus.q,      1'b0);
    chk("rst_q_n",    bus.q_n,    1'b1);
    chk("rst_set_db", bus.set_db, 1'b0);
    chk("rst_invalid", bus.invalid, 1'b0);
    #1 rst_n = 1'b1;

    // clean set: db on 4th edge (edge 3), pulse that cycle only, q one edge later
    step(1, 0); step(1, 0); step(1, 0);
    chk("clean_db_early", bus.set_db, 1'b0);
    step(1, 0);
    chk("clean_db",    bus.set_db,    1'b1);
    chk("clean_pulse", bus.set_pulse, 1'b1);
    chk("clean_q_pre", bus.q,         1'b0);
    step(1, 0);
    chk("clean_pulse_off", bus.set_pulse, 1'b0);
    chk("clean_q",         bus.q,         1'b1);

    // bounce: 1,1,1,0,1,1,1,1 accepts only on edge index 7
    repeat (6) step(0, 0);
    chk("bounce_pre_db", bus.set_db, 1'b0);
    step(1, 0); step(1, 0); step(1, 0); step(0, 0);
    step(1, 0); step(1, 0); step(1, 0);
    chk("bounce_db6",    bus.set_db,    1'b0);
    chk("bounce_pulse6", bus.set_pulse, 1'b0);
    step(1, 0);
    chk("bounce_db7",    bus.set_db,    1'b1);
    chk("bounce_pulse7", bus.set_pulse, 1'b1);

    // simultaneous press with q=1: both strobes together, reset wins
    repeat (6) step(0, 0);
    chk("sim_q_pre", bus.q, 1'b1);
    repeat (4) step(1, 1);
    chk("sim_set_pulse",   bus.set_pulse,   1'b1);
    chk("sim_reset_pulse", bus.reset_pulse, 1'b1);
    chk("sim_invalid",     bus.invalid,     1'b1);
    step(1, 1);
    chk("sim_q",        bus.q,       1'b0);
    chk("sim_invalid2", bus.invalid, 1'b1);
    step(1, 1);

    // release of reset button: falls after 4 samples, no strobe, q unchanged
    step(1, 0); step(1, 0); step(1, 0);
    chk("rel_db_hold", bus.reset_db, 1'b1);
    step(1, 0);
    chk("rel_db",      bus.reset_db,    1'b0);
    chk("rel_pulse",   bus.reset_pulse, 1'b0);
    chk("rel_q",       bus.q,           1'b0);
    chk("rel_invalid", bus.invalid,     1'b0);

    // mid-count reset discards partial count
    repeat (6) step(0, 0);
    step(1, 0); step(1, 0);
    assert_reset();
    step(1, 0);
    #1 rst_n = 1'b1;
    step(1, 0); step(1, 0); step(1, 0);
    chk("midrst_db_early", bus.set_db, 1'b0);
    step(1, 0);
    chk("midrst_db", bus.set_db, 1'b1);

    // randomized button activity with occasional resets
    begin
      bit s = 0;
      bit r = 0;
      for (int k = 0; k < 600; k++) begin
        int hold;
        if ($urandom_range(0, 1) == 0) s = ~s;
        if ($urandom_range(0, 2) == 0) r = ~r;
        hold = (($urandom_range(0, 2) == 0) ? $urandom_range(3, 7) : $urandom_range(1, 3));
        for (int h = 0; h < hold; h++) step(s, r);
        if ($urandom_range(0, 59) == 0) begin
          assert_reset();
          step(s, r);
          #1 rst_n = 1'b1;
        end
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
